// File: rtl/size_patch_writer.sv
// Queues size-field patch requests and writes each one back as consecutive
// big-endian byte stores into the output buffer.
module size_patch_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] offset_addr,
  input  logic [31:0] val,
  input  logic [31:0] byte_size,
  input  logic [31:0] base_addr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        patch_done,
  output logic [31:0] patch_count,
  output logic        overflow,
  output logic        size_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  function automatic logic [7:0] pick_byte(input logic [31:0] v, input logic [1:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [1:0] last_index(input logic [2:0] size);
    return size[2] ? 2'd3 : (size[1:0] - 2'd1);
  endfunction

  state_t state, next_state;

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_val  [DEPTH];
  logic [2:0]  fifo_size [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic req_vld, size_bad, push, pop, fifo_empty;

  logic [31:0] cur_addr;
  logic [31:0] cur_val;
  logic [1:0]  cur_last;
  logic [1:0]  k;

  assign size_bad   = byte_size > 32'd4;
  assign req_vld    = (byte_size != 32'd0) && !size_bad;
  assign fifo_empty = (count == '0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push       = req_vld && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= base_addr + offset_addr;
      fifo_val[wr_ptr]  <= val;
      fifo_size[wr_ptr] <= byte_size[2:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (k == 2'd0) begin
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Patch datapath: head entry is latched on pop, k walks MSB to LSB.
  always_ff @(posedge clock) begin
    if (pop) begin
      cur_addr <= fifo_addr[rd_ptr];
      cur_val  <= fifo_val[rd_ptr];
      cur_last <= last_index(fifo_size[rd_ptr]);
      k        <= last_index(fifo_size[rd_ptr]);
    end else if (state == WRITE && k != 2'd0) begin
      k <= k - 2'd1;
    end
  end

  always_comb begin
    mem_we     = (state == WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    patch_done = 1'b0;
    if (mem_we) begin
      mem_addr   = cur_addr + {30'd0, cur_last - k};
      mem_wdata  = pick_byte(cur_val, k);
      patch_done = (k == 2'd0);
    end
  end

  assign busy = !fifo_empty || (state == WRITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      patch_count <= '0;
      overflow    <= 1'b0;
      size_error  <= 1'b0;
    end else begin
      if (patch_done)       patch_count <= patch_count + 32'd1;
      if (req_vld && !push) overflow    <= 1'b1;
      if (size_bad)         size_error  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_size_patch_writer.sv
// Randomized bench for size_patch_writer against a schedule-level model that
// predicts every cycle's byte write, completion count and sticky flags.
module tb_size_patch_writer;

  localparam int DEPTH = 4;
  localparam int NCYC  = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] offset_addr = '0;
  logic [31:0] val = '0;
  logic [31:0] byte_size = '0;
  logic [31:0] base_addr = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        patch_done;
  logic [31:0] patch_count;
  logic        overflow;
  logic        size_error;

  size_patch_writer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .offset_addr(offset_addr), .val(val),
    .byte_size(byte_size), .base_addr(base_addr), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .patch_done(patch_done), .patch_count(patch_count),
    .overflow(overflow), .size_error(size_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  // Expected behaviour per cycle, filled in when a request is accepted.
  bit        e_we   [NCYC];
  bit [31:0] e_addr [NCYC];
  bit [7:0]  e_data [NCYC];
  bit        e_done [NCYC];
  int        starts [$];
  int        last_end = -1;
  int        m_count  = 0;
  bit        m_ovf    = 1'b0;
  bit        m_serr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick(input bit rst, input logic [31:0] base, input logic [31:0] off,
                      input logic [31:0] v, input logic [31:0] bs);
    @(posedge clock);
    #1;
    reset = rst; base_addr = base; offset_addr = off; val = v; byte_size = bs;
    cyc++;
    if (cyc >= NCYC - 16) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, cyc, NCYC - 16);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clock);
    if (armed) begin
      chk("mem_we",      {31'd0, mem_we},     {31'd0, e_we[cyc]});
      chk("mem_addr",    mem_addr,            e_addr[cyc]);
      chk("mem_wdata",   {24'd0, mem_wdata},  {24'd0, e_data[cyc]});
      chk("patch_done",  {31'd0, patch_done}, {31'd0, e_done[cyc]});
      chk("patch_count", patch_count,         32'(m_count));
      chk("busy",        {31'd0, busy},       {31'd0, (last_end >= cyc)});
      chk("overflow",    {31'd0, overflow},   {31'd0, m_ovf});
      chk("size_error",  {31'd0, size_error}, {31'd0, m_serr});
      if (e_done[cyc]) m_count++;
    end
    while (starts.size() > 0 && starts[0] < cyc) void'(starts.pop_front());
    if (rst) begin
      for (int c = cyc + 1; c < NCYC; c++) begin
        e_we[c] = 1'b0; e_addr[c] = '0; e_data[c] = '0; e_done[c] = 1'b0;
      end
      starts.delete();
      last_end = -1; m_count = 0; m_ovf = 1'b0; m_serr = 1'b0;
      armed = 1'b1;
    end else if (bs > 32'd4) begin
      m_serr = 1'b1;
    end else if (bs != 32'd0) begin
      int queued = 0;
      int st;
      foreach (starts[i]) if (starts[i] - 1 > cyc) queued++;
      if (queued < DEPTH) begin
        st = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
        starts.push_back(st);
        for (int j = 0; j < int'(bs); j++) begin
          e_we[st + j]   = 1'b1;
          e_addr[st + j] = base + off + 32'(j);
          e_data[st + j] = 8'(v >> (8 * (int'(bs) - 1 - j)));
          e_done[st + j] = (j == int'(bs) - 1);
        end
        last_end = st + int'(bs) - 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    tick(1'b1, '0, '0, '0, '0);
    tick(1'b1, '0, '0, '0, '0);
    idle(2);

    tick(1'b0, 32'h0, 32'h10, 32'h1234, 32'd2);
    idle(4);
    tick(1'b0, 32'h100, 32'h21, 32'hAABB_CCDD, 32'd4);
    idle(6);

    for (int i = 0; i < 8; i++) tick(1'b0, 32'h2000, 32'(i * 8), $urandom, 32'd4);
    idle(30);

    tick(1'b0, 32'h300, 32'h4, 32'h1111_2222, 32'd5);
    idle(3);
    tick(1'b0, 32'h300, 32'h4, 32'h1111_2222, 32'd0);
    idle(3);
    tick(1'b1, '0, '0, '0, '0);

    tick(1'b0, 32'h400, 32'h1, 32'h5A, 32'd1);
    tick(1'b0, 32'h400, 32'h2, 32'hC3, 32'd1);
    idle(4);

    tick(1'b0, 32'h500, 32'h0, 32'h0102_0304, 32'd4);
    tick(1'b0, 32'h500, 32'h8, 32'h0506_0708, 32'd3);
    tick(1'b0, 32'h500, 32'h10, 32'h090A_0B0C, 32'd2);
    tick(1'b1, 32'h600, 32'h0, 32'hFFFF_FFFF, 32'd4);
    idle(10);

    for (int i = 0; i < 2500; i++) begin
      int r;
      logic [31:0] bs;
      r = $urandom_range(0, 9);
      if (r < 4)       bs = 32'd0;
      else if (r < 8)  bs = 32'(r - 3);
      else if (r == 8) bs = 32'($urandom_range(5, 9));
      else             bs = $urandom;
      tick($urandom_range(0, 199) == 0, $urandom, $urandom, $urandom, bs);
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/size_patch_writer.md
SIZE_PATCH_WRITER -- requirements
Module: size_patch_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of patch-request FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port offset_addr, input, 32 bits: byte offset of the size field to patch.
REQ-005 SHALL have port val, input, 32 bits: the size value to write, right-justified.
REQ-006 SHALL have port byte_size, input, 32 bits: field width in bytes; a nonzero value marks a request in that cycle.
REQ-007 SHALL have port base_addr, input, 32 bits: output-buffer base, sampled together with each request.
REQ-008 SHALL have port mem_we, output, 1 bit: byte write strobe.
REQ-009 SHALL have port mem_addr, output, 32 bits: byte address of the write.
REQ-010 SHALL have port mem_wdata, output, 8 bits: byte data of the write.
REQ-011 SHALL have port busy, output, 1 bit: high while the FIFO is non-empty or a patch is in progress.
REQ-012 SHALL have port patch_done, output, 1 bit: one-cycle pulse, coincident with the last byte write of a patch.
REQ-013 SHALL have port patch_count, output, 32 bits: number of completed patches, wrapping modulo 2^32.
REQ-014 SHALL have port overflow, output, 1 bit: sticky; a request was dropped because the FIFO was full.
REQ-015 SHALL have port size_error, output, 1 bit: sticky; a request had byte_size greater than 4.

Function
REQ-016 SHALL have no backpressure: each request is a one-cycle presentation that is either accepted or dropped.
REQ-017 SHALL ignore byte_size 0; byte_size 1-4 is a valid request; byte_size above 4 is dropped and sets size_error.
REQ-018 SHALL store {base_addr+offset_addr (32-bit wrap), val, byte_size[2:0]} per FIFO entry.
REQ-019 SHALL push a valid request when the registered count < DEPTH, or when a pop occurs at the same edge.
REQ-020 SHALL otherwise drop the request and set overflow; FIFO contents and count are unchanged.
REQ-021 SHALL implement a two-state FSM, IDLE and WRITE.
REQ-022 SHALL in IDLE with the FIFO non-empty: pop the head and go to WRITE with byte index k = byte_size-1.
REQ-023 SHALL in WRITE: drive mem_we=1, mem_addr=addr+(byte_size-1-k), mem_wdata=val[8k+7:8k], then decrement k (big-endian, MSB first).
REQ-024 SHALL on the WRITE cycle with k=0: pulse patch_done, increment patch_count, and then either pop the next entry and stay in WRITE with no bubble (FIFO non-empty) or return to IDLE.
REQ-025 SHALL give a request presented in cycle T its first byte write in cycle T+2; an n-byte patch occupies n consecutive cycles.
REQ-026 SHALL hold mem_we=0 outside WRITE; mem_addr and mem_wdata are then 0.
REQ-027 SHALL allow overflow and size_error to be cleared only by reset.

Reset
REQ-028 SHALL on reset: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, patch_done=0, patch_count=0, overflow=0, size_error=0, FSM=IDLE, FIFO empty.
REQ-029 SHALL on reset mid-patch: abort the patch with no further bytes written, discard all queued entries, and ignore a request presented in the reset cycle.

Verification
REQ-030 SHALL pass single patch: base 0, offset 0x10, val 0x1234, size 2 at T -> writes (0x10,0x12) at T+2 and (0x11,0x34) at T+3, patch_done at T+3, patch_count=1.
REQ-031 SHALL pass 4-byte patch: base 0x100, offset 0x21, val 0xAABBCCDD -> writes 0x121..0x124 = AA, BB, CC, DD on consecutive cycles.
REQ-032 SHALL pass overflow: DEPTH=4, 8 back-to-back size-4 requests -> requests 7 and 8 dropped, overflow=1, 24 strobes with no gaps, patch_count=6.
REQ-033 SHALL pass size checks: size 5 -> no write, size_error=1; size 0 -> no write, no flag, busy stays 0.
REQ-034 SHALL pass back-to-back: two size-1 requests at T and T+1 -> writes at T+2 and T+3, two patch_done pulses.
REQ-035 SHALL pass reset mid-patch: reset during byte 2 of a 4-byte patch with 2 entries queued -> mem_we=0 next cycle, busy=0, counters and flags 0, no later writes.
